// File: rtl/addsub_arbiter_2ch.sv
// Two-channel round-robin arbiter feeding one shared add/subtract datapath.
// Grants in IDLE, computes in EXEC, and holds the registered result in RESP until it is consumed.
module addsub_arbiter_2ch #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sel,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sel,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  input  logic             rsp_ready,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens on the rising edge where valid && ready are
  // both high. reqN_ready never depends on anything but state, prio and the
  // valids. rsp_valid stays high, with the payload stable, until rsp_ready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             prio;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sel;
  logic             op_id;
  logic             grant_id;
  logic             grant_any;
  logic             take;
  logic [WIDTH:0]   dp_res;

  // prio only breaks ties; a lone requester always wins.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant_id = prio;
    else                          grant_id = req1_valid;
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    take       = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          take       = 1'b1;
          state_nxt  = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Subtract as a + ~b + 1; the carry-out then reads as "no borrow" (a >= b).
  always_comb begin
    dp_res = {1'b0, op_a} + {1'b0, (op_sel ? ~op_b : op_b)} + {{WIDTH{1'b0}}, op_sel};
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      prio     <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_sel   <= 1'b0;
      op_id    <= 1'b0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_id   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        op_a   <= grant_id ? req1_a   : req0_a;
        op_b   <= grant_id ? req1_b   : req0_b;
        op_sel <= grant_id ? req1_sel : req0_sel;
        op_id  <= grant_id;
        prio   <= ~grant_id;
      end
      if (state == EXEC) begin
        rsp_sum  <= dp_res[WIDTH-1:0];
        rsp_cout <= dp_res[WIDTH];
        rsp_id   <= op_id;
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_addsub_arbiter_2ch.sv
// Self-checking bench for addsub_arbiter_2ch: directed scenarios plus a
// randomized run against a transaction-level arithmetic/arbitration model.
module tb_addsub_arbiter_2ch;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk;
  logic         RESET;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_sel, req1_sel;
  logic         req0_ready, req1_ready;
  logic         rsp_valid, rsp_id, rsp_cout, rsp_ready, busy;
  logic [W-1:0] rsp_sum;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic         model_prio;
  logic [W+1:0] exp_q[$];   // {id, cout, sum}

  addsub_arbiter_2ch #(.WIDTH(W)) dut (
    .clk(clk), .RESET(RESET),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sel(req0_sel), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sel(req1_sel), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .rsp_ready(rsp_ready), .busy(busy),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W+1:0] model_op(input logic id, input int a, input int b,
                                            input logic sel);
    int   s;
    logic c;
    if (!sel) begin
      s = a + b;
      c = (s >= MOD);
      s = s % MOD;
    end else begin
      c = (a >= b);
      s = (a - b + MOD) % MOD;
    end
    return {id, c, s[W-1:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int ch, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sel);
    if (ch == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel;
    end
  endtask

  task automatic drive_rand(input int ch);
    drive_req(ch, W'($urandom_range(0, MOD-1)), W'($urandom_range(0, MOD-1)),
              1'($urandom_range(0, 1)));
  endtask

  task automatic clear_reqs();
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  function automatic logic [W+1:0] pending_op(input int ch);
    if (ch == 0) return model_op(1'b0, int'(req0_a), int'(req0_b), req0_sel);
    else         return model_op(1'b1, int'(req1_a), int'(req1_b), req1_sel);
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RESET = 1'b0; rsp_ready = 1'b1;
    clear_reqs();
    req0_a = '0; req0_b = '0; req0_sel = 1'b0;
    req1_a = '0; req1_b = '0; req1_sel = 1'b0;
    model_prio = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({rsp_valid, busy, rsp_id, rsp_cout, rsp_sum} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b busy=%b id=%b cout=%b sum=%b, want all 0",
               rsp_valid, busy, rsp_id, rsp_cout, rsp_sum);
    end
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready_idle: got %b%b, want 00", req0_ready, req1_ready);
    end
    RESET = 1'b1;
  endtask

  task automatic test_single_add();
    @(negedge clk);
    drive_req(0, 4'd3, 4'd4, 1'b0);
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL add_ready: got r0=%b r1=%b, want r0=1 r1=0", req0_ready, req1_ready);
    end
    model_prio = 1'b1;
    @(posedge clk); #1;
    clear_reqs();
    n_checks++;
    if ({rsp_valid, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL add_exec_phase: got valid=%b busy=%b, want valid=0 busy=1", rsp_valid, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_cout, rsp_sum} !== {1'b1, 1'b0, 1'b0, 4'b0111}) begin
      n_fail++;
      $display("FAIL add_result: got valid=%b id=%b cout=%b sum=%b, want 1 0 0 0111",
               rsp_valid, rsp_id, rsp_cout, rsp_sum);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL add_return_idle: got valid=%b busy=%b, want 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_sub_boundary();
    logic [W-1:0] ta[4], tbv[4], tsum[4];
    logic         tsel[4], tcout[4];
    ta = '{4'd7, 4'd3, 4'd4, 4'd14};
    tbv = '{4'd3, 4'd4, 4'd8, 4'd5};
    tsel = '{1'b1, 1'b1, 1'b1, 1'b0};
    tsum = '{4'b0100, 4'b1111, 4'b1100, 4'b0011};
    tcout = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      int n;
      @(negedge clk);
      drive_req(1, ta[i], tbv[i], tsel[i]);
      #1;
      n_checks++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
        n_fail++;
        $display("FAIL sub_ready[%0d]: got r0=%b r1=%b, want 0 1", i, req0_ready, req1_ready);
      end
      model_prio = 1'b0;
      @(posedge clk); #1;
      clear_reqs();
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 5) begin
        @(negedge clk);
        n++;
      end
      n_checks++;
      if (!rsp_valid) begin
        n_fail++;
        $display("FAIL sub_timeout[%0d]: rsp_valid never rose", i);
      end else if ({rsp_id, rsp_cout, rsp_sum} !== {1'b1, tcout[i], tsum[i]}) begin
        n_fail++;
        $display("FAIL sub_result[%0d]: got id=%b cout=%b sum=%b, want id=1 cout=%b sum=%b",
                 i, rsp_id, rsp_cout, rsp_sum, tcout[i], tsum[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int grants = 0;
    int last   = -1;
    int cyc    = 0;
    int gch;
    logic gflag;
    rsp_ready = 1'b1;
    @(negedge clk);
    drive_rand(0);
    drive_rand(1);
    while (grants < 4 && cyc < 40) begin
      #1;
      gflag = 1'b0;
      if (rsp_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_spurious_rsp: id=%b sum=%b with nothing outstanding", rsp_id, rsp_sum);
        end else begin
          if ({rsp_id, rsp_cout, rsp_sum} !== exp_q[0]) begin
            n_fail++;
            $display("FAIL b2b_rsp: got {id,cout,sum}=%b want %b",
                     {rsp_id, rsp_cout, rsp_sum}, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      if (req0_ready || req1_ready) begin
        gch = int'(model_prio);
        n_checks++;
        if ({req1_ready, req0_ready} !== (2'b01 << gch)) begin
          n_fail++;
          $display("FAIL b2b_grant_order: got r0=%b r1=%b, want channel %0d",
                   req0_ready, req1_ready, gch);
        end
        if (last >= 0) begin
          n_checks++;
          if (cyc - last != 3) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles between grants, want 3", cyc - last);
          end
        end
        exp_q.push_back(pending_op(gch));
        model_prio = ~model_prio;
        grants++;
        last  = cyc;
        gflag = 1'b1;
      end
      @(posedge clk); #1;
      if (gflag) begin
        if (grants == 4) clear_reqs();
        else drive_rand(gch);
      end
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (grants < 4) begin
      n_fail++;
      $display("FAIL b2b_timeout: got %0d grants, want 4", grants);
      clear_reqs();
    end
    for (int k = 0; k < 6 && exp_q.size() > 0; k++) begin
      if (rsp_valid) begin
        n_checks++;
        if ({rsp_id, rsp_cout, rsp_sum} !== exp_q[0]) begin
          n_fail++;
          $display("FAIL b2b_last_rsp: got %b want %b", {rsp_id, rsp_cout, rsp_sum}, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      @(negedge clk);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drain: %0d responses missing, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_backpressure();
    logic [W+1:0] exp;
    int n = 0;
    @(negedge clk);
    rsp_ready = 1'b0;
    drive_rand(1);
    exp = pending_op(1);
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_grant: got r0=%b r1=%b, want 0 1", req0_ready, req1_ready);
    end
    model_prio = 1'b0;
    @(posedge clk); #1;
    clear_reqs();
    @(negedge clk);
    while (!rsp_valid && n < 5) begin
      @(negedge clk);
      n++;
    end
    drive_rand(0);
    drive_rand(1);
    #1;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if ({rsp_valid, busy, req0_ready, req1_ready} !== 4'b1100 ||
          {rsp_id, rsp_cout, rsp_sum} !== exp) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got valid=%b busy=%b r0=%b r1=%b rsp=%b, want 1 1 0 0 rsp=%b",
                 c, rsp_valid, busy, req0_ready, req1_ready, {rsp_id, rsp_cout, rsp_sum}, exp);
      end
      @(negedge clk); #1;
    end
    clear_reqs();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL bp_release: got valid=%b busy=%b, want 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_reset_in_exec();
    logic [W+1:0] exp;
    int n = 0;
    @(negedge clk);
    drive_rand(0);
    drive_rand(1);
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== {~model_prio, model_prio}) begin
      n_fail++;
      $display("FAIL rst_pre_grant: got r0=%b r1=%b, want channel %0d",
               req0_ready, req1_ready, model_prio);
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_in_exec: busy=%b, want 1", busy);
    end
    #2;
    RESET = 1'b0;
    model_prio = 1'b0;
    #1;
    n_checks++;
    if ({rsp_valid, busy, rsp_id, rsp_cout, rsp_sum} !== '0) begin
      n_fail++;
      $display("FAIL rst_abort: got valid=%b busy=%b id=%b cout=%b sum=%b, want all 0",
               rsp_valid, busy, rsp_id, rsp_cout, rsp_sum);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_rsp: rsp_valid=%b during reset, want 0", rsp_valid);
    end
    @(negedge clk);
    RESET = 1'b1;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_prio_restart: got r0=%b r1=%b, want r0=1 r1=0", req0_ready, req1_ready);
    end
    exp = pending_op(0);
    model_prio = 1'b1;
    @(posedge clk); #1;
    clear_reqs();
    @(negedge clk);
    while (!rsp_valid && n < 5) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!rsp_valid || {rsp_id, rsp_cout, rsp_sum} !== exp) begin
      n_fail++;
      $display("FAIL rst_post_result: got valid=%b rsp=%b, want 1 rsp=%b",
               rsp_valid, {rsp_id, rsp_cout, rsp_sum}, exp);
    end
    @(posedge clk);
  endtask

  task automatic test_random();
    int   age = 0;
    int   exp_ch;
    logic q_empty;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = W'($urandom_range(0, MOD-1)); req0_b = W'($urandom_range(0, MOD-1));
      req1_a = W'($urandom_range(0, MOD-1)); req1_b = W'($urandom_range(0, MOD-1));
      req0_sel = 1'($urandom_range(0, 1));   req1_sel = 1'($urandom_range(0, 1));
      rsp_ready = ($urandom_range(0, 9) < 7);
      #1;
      q_empty = (exp_q.size() == 0);
      n_checks++;
      if (rsp_valid !== (!q_empty && age >= 2)) begin
        n_fail++;
        $display("FAIL rnd_rsp_valid[%0d]: got %b, want %b", cyc, rsp_valid, (!q_empty && age >= 2));
      end
      if (q_empty && (req0_valid || req1_valid)) begin
        exp_ch = (req0_valid && req1_valid) ? int'(model_prio) : int'(req1_valid);
      end else begin
        exp_ch = -1;
      end
      n_checks++;
      if ({req1_ready, req0_ready} !== ((exp_ch < 0) ? 2'b00 : (2'b01 << exp_ch))) begin
        n_fail++;
        $display("FAIL rnd_ready[%0d]: got r0=%b r1=%b, want channel %0d (-1 = none)",
                 cyc, req0_ready, req1_ready, exp_ch);
      end
      if (rsp_valid && rsp_ready && !q_empty) begin
        n_checks++;
        if ({rsp_id, rsp_cout, rsp_sum} !== exp_q[0]) begin
          n_fail++;
          $display("FAIL rnd_rsp[%0d]: got {id,cout,sum}=%b want %b",
                   cyc, {rsp_id, rsp_cout, rsp_sum}, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      if (exp_ch >= 0) begin
        exp_q.push_back(pending_op(exp_ch));
        model_prio = (exp_ch == 0);
        age = 0;
      end
      @(posedge clk);
      if (exp_q.size() != 0) age++;
    end
    @(negedge clk);
    clear_reqs();
    rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_sub_boundary();
    test_back_to_back();
    test_backpressure();
    test_reset_in_exec();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
